// File: rtl/stream_capture_pkg.sv
// Shared types and constants for the stream-to-BRAM capture block.
package stream_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

    localparam logic CAPTURE_IMMEDIATE = 1'b0;
    localparam logic CAPTURE_ORBIT     = 1'b1;

    // Zero or any request at/above the RAM depth means "fill the whole RAM".
    function automatic logic [16:0] clamp_length(input logic [15:0] req,
                                                 input logic [16:0] depth);
        logic [16:0] len;
        if ((req == 16'd0) || ({1'b0, req} >= depth)) begin
            len = depth;
        end else begin
            len = {1'b0, req};
        end
        return len;
    endfunction

endpackage

// File: rtl/stream_to_bram.sv
// Records a 32-bit AXI stream into a block RAM through a native write port.
// Capture starts on arm (immediate mode) or on the first orbit sync after arm,
// stores a latched number of words, then stops and raises done.
module stream_to_bram
    import stream_capture_pkg::*;
#(
    parameter  int MEM_DEPTH = 2048,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        clear,
    input  logic        capture_mode,
    input  logic [15:0] capture_length,
    input  logic        fc_orbitSync,
    input  logic [31:0] data_stream_TDATA,
    input  logic        data_stream_TVALID,
    output logic        data_stream_TREADY,
    output logic        bram_CLK,
    output logic        bram_RST,
    output logic        bram_EN,
    output logic [3:0]  bram_WE,
    output logic [31:0] bram_ADDR,
    output logic [31:0] bram_DIN,
    output logic        busy,
    output logic        done,
    output logic [16:0] words_written
);

    localparam logic [16:0] DEPTH_W = 17'(MEM_DEPTH);

    typedef struct packed {
        capture_state_t state;
        logic           ready;
        logic           mode;
        logic [16:0]    len;
        logic [AW-1:0]  addr;
        logic [16:0]    count;
        logic           en;
        logic [AW-1:0]  wr_addr;
        logic [31:0]    din;
        logic           done;
    } regs_t;

    regs_t       q_r;
    regs_t       d_s;
    logic        accept_s;
    logic        write_s;
    logic [16:0] next_count_s;

    // Next-state and write-port decode; clear overrides every transition and write.
    always_comb begin
        d_s          = q_r;
        d_s.ready    = 1'b1;
        d_s.en       = 1'b0;
        write_s      = 1'b0;
        accept_s     = data_stream_TVALID && q_r.ready;
        next_count_s = q_r.count + 17'd1;

        if (clear) begin
            d_s.state = IDLE;
        end else begin
            case (q_r.state)
                IDLE, DONE: begin
                    if (arm) begin
                        d_s.len   = clamp_length(capture_length, DEPTH_W);
                        d_s.mode  = capture_mode;
                        d_s.count = 17'd0;
                        d_s.addr  = '0;
                        if (capture_mode == CAPTURE_ORBIT) begin
                            d_s.state = ARMED;
                        end else begin
                            d_s.state = CAPTURE;
                        end
                    end else begin
                        d_s.state = q_r.state;
                    end
                end
                ARMED: begin
                    if (fc_orbitSync) begin
                        d_s.state = CAPTURE;
                        write_s   = accept_s;
                    end else begin
                        d_s.state = ARMED;
                    end
                end
                CAPTURE: begin
                    write_s = accept_s;
                end
                default: begin
                    d_s.state = IDLE;
                end
            endcase

            if (write_s) begin
                d_s.en      = 1'b1;
                d_s.wr_addr = q_r.addr;
                d_s.din     = data_stream_TDATA;
                d_s.count   = next_count_s;
                // Address stops at len-1 on the final word, so it never wraps.
                if (next_count_s >= q_r.len) begin
                    d_s.state = DONE;
                end else begin
                    d_s.addr = q_r.addr + 1'b1;
                end
            end else begin
                d_s.en = 1'b0;
            end
        end

        // done trails the DONE entry by one cycle and drops as soon as we leave.
        d_s.done = (q_r.state == DONE) && (d_s.state == DONE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else begin
            q_r <= d_s;
        end
    end

    assign data_stream_TREADY = q_r.ready;
    assign bram_CLK           = clk;
    assign bram_RST           = reset;
    assign bram_EN            = q_r.en;
    assign bram_WE            = q_r.en ? 4'hF : 4'h0;
    assign bram_ADDR          = {{(30 - AW){1'b0}}, q_r.wr_addr, 2'b00};
    assign bram_DIN           = q_r.din;
    assign busy               = (q_r.state == ARMED) || (q_r.state == CAPTURE);
    assign done               = q_r.done;
    assign words_written      = q_r.count;

endmodule

// File: doc/stream_to_bram.md
# stream_to_bram

Captures a 32-bit AXI stream into a block RAM through a native BRAM write port. It is the write-side counterpart of the BRAM-sourced pattern player: the player replays RAM contents onto a link, and this block records a link's stream into RAM for readback. Capture starts either immediately or aligned to the fast-command orbit sync, stores a programmed number of words, then stops and flags completion.

## Interface
- MEM_DEPTH, 2048: BRAM depth in 32-bit words; power of two, at most 65536.
- AW, $clog2(MEM_DEPTH): word-address width (derived, not overridden).
- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts a capture sequence.
- clear  in  1  single-cycle pulse; aborts any capture and returns to IDLE.
- capture_mode  in  1  0: start on arm; 1: start on the first fc_orbitSync after arm.
- capture_length  in  16  number of words to store; 0 or any value >= MEM_DEPTH means MEM_DEPTH.
- fc_orbitSync  in  1  orbit-sync strobe from the fast-command decoder.
- data_stream_TDATA  in  32  input stream data.
- data_stream_TVALID  in  1  input stream valid.
- data_stream_TREADY  out  1  always 1 outside reset; the block never back-pressures.
- bram_CLK  out  1  equals clk.
- bram_RST  out  1  equals reset.
- bram_EN  out  1  registered; high only on write cycles.
- bram_WE  out  4  registered; 4'hF on write cycles, else 0.
- bram_ADDR  out  32  registered byte address: zeros above bit AW+1, then the word address, then 2'b00.
- bram_DIN  out  32  registered write data.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- words_written  out  17  words stored in the current or last capture.

## Operation
- A beat is accepted when TVALID && TREADY. Only beats accepted in CAPTURE are written; all other beats are discarded.
- capture_length and capture_mode are latched on the arm pulse into len_q (17 bits after clamping) and mode_q. Later changes have no effect until the next arm.
- States (enum): IDLE, ARMED, CAPTURE, DONE.
  - IDLE: on arm, go to CAPTURE if capture_mode=0, otherwise to ARMED. Clear words_written and the word address.
  - ARMED: on fc_orbitSync, go to CAPTURE. The beat accepted in that same cycle is stored as word 0.
  - CAPTURE: each accepted beat is written at the current word address, which then increments. When words_written reaches len_q, go to DONE.
  - DONE: hold. arm re-enters the arm sequence exactly as from IDLE.
- In mode 0, the beat accepted in the arm cycle is not stored. The first stored beat is the one accepted in the cycle after arm.
- arm received in ARMED or CAPTURE is ignored.
- clear has priority over arm and over any state transition: go to IDLE, and discard any write not yet registered. words_written holds its value.
- The word address never exceeds len_q-1, so no wrap-around occurs. Gaps in TVALID during CAPTURE stall the address; no write is issued.
- fc_orbitSync outside ARMED is ignored. In the arm cycle it does not trigger, because the trigger requires being in ARMED on the prior cycle.

## Timing
- Write latency is 1 cycle: a beat accepted in cycle N is presented on bram_DIN, bram_ADDR and bram_WE/bram_EN in cycle N+1.
- words_written increments in the same edge that registers the write. done rises in the cycle after the last write is presented.
- Reset values: data_stream_TREADY=0, bram_EN=0, bram_WE=0, bram_ADDR=0, bram_DIN=0, busy=0, done=0, words_written=0, state=IDLE.
- TREADY goes to 1 on the first cycle after reset deasserts.
- Reset asserted mid-capture: state returns to IDLE on the next edge. Any pending write is dropped (WE=0), and RAM contents already written are left untouched.

## Structure
- Package stream_capture_pkg holds the state enum (capture_state_t) and the mode constants CAPTURE_IMMEDIATE=1'b0 and CAPTURE_ORBIT=1'b1.
- Single module, no sub-modules. Registers are kept in a d/q struct pair with a combinational next-state block.

## Test plan
- Mode 0, length 4, continuous TVALID with data 0x100 through 0x105 starting in the arm cycle -> writes 0x101..0x104 at ADDR 0x0, 0x4, 0x8, 0xC; words_written=4; done=1; no further WE.
- Mode 1, length 3, fc_orbitSync 10 cycles after arm, data equal to the cycle count -> first write carries the orbitSync-cycle data at ADDR 0; busy stays high until done.
- TVALID toggling 1,0,0,1,1 in CAPTURE with length 3 -> exactly 3 writes at consecutive addresses; WE=0 during the gap cycles.
- capture_length=0 with MEM_DEPTH=2048 -> 2048 writes; last ADDR=0x1FFC; words_written=2048; no address wrap.
- clear asserted after 2 of 8 writes -> returns to IDLE, no further WE, words_written=2. A new arm then restarts at ADDR 0.
- reset asserted mid-capture -> all outputs return to reset values within 1 cycle; TREADY=1 on the first cycle after release.
